// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 constants, prefix FSM states, key event record and arrow-key decode
package ps2_pkg;
  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
  localparam logic [7:0] PS2_KEY_UP     = 8'h75;
  localparam logic [7:0] PS2_KEY_LEFT   = 8'h6B;
  localparam logic [7:0] PS2_KEY_DOWN   = 8'h72;
  localparam logic [7:0] PS2_KEY_RIGHT  = 8'h74;
  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} ps2_state_e;
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ps2_evt_t;
  // One-hot {right, down, left, up} for an extended arrow scan code
  function automatic logic [3:0] arrow_mask(input logic [7:0] code);
    return {code == PS2_KEY_RIGHT, code == PS2_KEY_DOWN, code == PS2_KEY_LEFT, code == PS2_KEY_UP};
  endfunction
endpackage

// File: rtl/ps2_key_event_rx_if.sv
// ps2_key_event_rx_if: valid/ready key event stream from the receiver to its consumer
interface ps2_key_event_rx_if;
  logic       EVT_VALID;
  logic       EVT_READY;
  logic [7:0] EVT_CODE;
  logic       EVT_EXT;
  logic       EVT_BREAK;
  modport master (output EVT_VALID, EVT_CODE, EVT_EXT, EVT_BREAK, input EVT_READY);
  modport slave (input EVT_VALID, EVT_CODE, EVT_EXT, EVT_BREAK, output EVT_READY);
endinterface

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises the PS/2 pins, samples them on a divided tick and checks 11-bit frames
module ps2_frame_rx #(
  parameter int CLK_DIV       = 250,
  parameter int TIMEOUT_TICKS = 4000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic [DW-1:0] div_q, div_d;
  logic prev_clk_q, prev_clk_d;
  logic [10:0] shift_q, shift_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [TW-1:0] idle_q, idle_d;
  logic ps2_clk_s, ps2_data_s, tick, fall, check, frame_ok, timeout;
  assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
  assign tick     = div_q == DW'(CLK_DIV - 1);
  assign fall     = tick && prev_clk_q && !ps2_clk_s;
  assign check    = tick && bitcnt_q == 4'd11;
  // start low, stop high, odd parity across data and parity bit
  assign frame_ok = !shift_q[0] && shift_q[10] && ^shift_q[9:1];
  assign timeout  = tick && !fall && bitcnt_q != 4'd0 && bitcnt_q != 4'd11 && idle_q == TW'(TIMEOUT_TICKS - 1);
  assign byte_valid_o = check && frame_ok;
  assign byte_o       = shift_q[8:1];
  assign frame_err_o  = (check && !frame_ok) || timeout;
  always_comb begin
    div_d      = tick ? '0 : div_q + 1'b1;
    prev_clk_d = tick ? ps2_clk_s : prev_clk_q;
    shift_d    = fall && !check ? {ps2_data_s, shift_q[10:1]} : shift_q;
    bitcnt_d   = check || timeout ? 4'd0 : fall ? bitcnt_q + 4'd1 : bitcnt_q;
    idle_d     = fall || timeout || check || bitcnt_q == 4'd0 ? '0 : tick ? idle_q + 1'b1 : idle_q;
  end
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      div_q       <= '0;
      prev_clk_q  <= 1'b1;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      idle_q      <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      div_q       <= div_d;
      prev_clk_q  <= prev_clk_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      idle_q      <= idle_d;
    end
  end
endmodule

// File: rtl/ps2_key_event_rx.sv
// ps2_key_event_rx: PS/2 keyboard receiver merging E0/F0 prefixes into buffered key events
// Define PS2_RX_KEYSTATE_EN to add the KEY_HELD arrow-key state output.
module ps2_key_event_rx import ps2_pkg::*; #(
  parameter int CLK_DIV       = 250,
  parameter int TIMEOUT_TICKS = 4000,
  parameter int FIFO_DEPTH    = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic               PS2_CLK,
  input  logic               PS2_DATA,
  ps2_key_event_rx_if.master evt,
  output logic               FRAME_ERR,
  output logic               OVERFLOW
`ifdef PS2_RX_KEYSTATE_EN
  ,
  output logic [3:0]         KEY_HELD
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic rx_valid, rx_err, push, pop, empty, full, wr_en;
  logic [7:0] rx_byte;
  ps2_state_e state_q, state_d;
  ps2_evt_t push_evt, head;
  ps2_evt_t mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic frame_err_q, overflow_q;
  ps2_frame_rx #(
    .CLK_DIV(CLK_DIV),
    .TIMEOUT_TICKS(TIMEOUT_TICKS),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_frame (
    .CLK(CLK),
    .RESETN(RESETN),
    .ps2_clk_i(PS2_CLK),
    .ps2_data_i(PS2_DATA),
    .byte_valid_o(rx_valid),
    .byte_o(rx_byte),
    .frame_err_o(rx_err)
  );
  // A second prefix after F0 is malformed: abandon the sequence without an event
  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    push_evt = '{code: rx_byte, ext: state_q == ST_EXT || state_q == ST_EXT_BRK, brk: state_q == ST_BRK || state_q == ST_EXT_BRK};
    if (rx_err) begin
      state_d = ST_IDLE;
    end else if (rx_valid) begin
      push = rx_byte != PS2_EXT_PREFIX && rx_byte != PS2_BRK_PREFIX;
      if (state_q == ST_IDLE)
        state_d = rx_byte == PS2_EXT_PREFIX ? ST_EXT : rx_byte == PS2_BRK_PREFIX ? ST_BRK : ST_IDLE;
      else if (state_q == ST_EXT)
        state_d = rx_byte == PS2_BRK_PREFIX ? ST_EXT_BRK : rx_byte == PS2_EXT_PREFIX ? ST_EXT : ST_IDLE;
      else
        state_d = ST_IDLE;
    end
  end
  assign empty = wr_q == rd_q;
  assign full  = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
  assign pop   = !empty && evt.EVT_READY;
  assign wr_en = push && (!full || pop);
  assign head  = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign evt.EVT_VALID = !empty;
  assign evt.EVT_CODE  = head.code;
  assign evt.EVT_EXT   = head.ext;
  assign evt.EVT_BREAK = head.brk;
  assign FRAME_ERR = frame_err_q;
  assign OVERFLOW  = overflow_q;
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= push_evt;
  end
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q     <= ST_IDLE;
      wr_q        <= '0;
      rd_q        <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_en ? wr_q + 1'b1 : wr_q;
      rd_q        <= pop ? rd_q + 1'b1 : rd_q;
      frame_err_q <= rx_err;
      overflow_q  <= overflow_q || (push && full && !pop);
    end
  end
`ifdef PS2_RX_KEYSTATE_EN
  logic [3:0] held_q, held_d, mask;
  assign mask     = arrow_mask(push_evt.code);
  assign held_d   = push && push_evt.ext ? (push_evt.brk ? held_q & ~mask : held_q | mask) : held_q;
  assign KEY_HELD = held_q;
  always_ff @(posedge CLK) begin
    if (!RESETN) held_q <= '0;
    else held_q <= held_d;
  end
`endif
endmodule

// File: tb/tb_ps2_key_event_rx.sv
// tb_ps2_key_event_rx: directed and random PS/2 byte streams checked against a prefix/FIFO reference model
module tb_ps2_key_event_rx;
  localparam int CLK_DIV = 4, TIMEOUT_TICKS = 40, FIFO_DEPTH = 4, SYNC_STAGES = 2, H = 16;
  logic clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic frame_err, overflow;
`ifdef PS2_RX_KEYSTATE_EN
  logic [3:0] key_held;
`endif
  int checks = 0, passes = 0, err_cnt = 0, exp_err = 0;
  logic [9:0] got[$], exp_q[$];
  logic pend_ext = 1'b0, pend_brk = 1'b0;
  logic [3:0] held = 4'd0;
  logic [7:0] c [5];
  ps2_key_event_rx_if ev();
  ps2_key_event_rx #(
    .CLK_DIV(CLK_DIV),
    .TIMEOUT_TICKS(TIMEOUT_TICKS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .CLK(clk),
    .RESETN(rst_n),
    .PS2_CLK(ps2_clk),
    .PS2_DATA(ps2_data),
    .evt(ev),
    .FRAME_ERR(frame_err),
    .OVERFLOW(overflow)
`ifdef PS2_RX_KEYSTATE_EN
    ,
    .KEY_HELD(key_held)
`endif
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rst_n && ev.EVT_VALID && ev.EVT_READY) got.push_back({ev.EVT_CODE, ev.EVT_EXT, ev.EVT_BREAK});
    if (frame_err) err_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic ps2_bit(input logic b);
    ps2_data = b;
    clks(H);
    ps2_clk = 1'b0;
    clks(H);
    ps2_clk = 1'b1;
  endtask
  task automatic send_frame(input logic [7:0] d, input logic bad);
    logic [10:0] f;
    f = {1'b1, ~^d ^ bad, d, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    clks(2 * H);
  endtask
  // Reference: a byte stream becomes events by accumulating prefix flags
  task automatic model_byte(input logic [7:0] d);
    if (d == 8'hE0 || d == 8'hF0) begin
      if (pend_brk) begin
        pend_ext = 1'b0;
        pend_brk = 1'b0;
      end else if (d == 8'hE0) pend_ext = 1'b1;
      else pend_brk = 1'b1;
    end else begin
      exp_q.push_back({d, pend_ext, pend_brk});
      if (pend_ext) begin
        if (d == 8'h75) held[0] = !pend_brk;
        if (d == 8'h6B) held[1] = !pend_brk;
        if (d == 8'h72) held[2] = !pend_brk;
        if (d == 8'h74) held[3] = !pend_brk;
      end
      pend_ext = 1'b0;
      pend_brk = 1'b0;
    end
  endtask
  task automatic send(input logic [7:0] d, input logic bad);
    send_frame(d, bad);
    if (bad) begin
      pend_ext = 1'b0;
      pend_brk = 1'b0;
      exp_err++;
    end else model_byte(d);
  endtask
  task automatic check_events(input string tag);
    chk({tag, " count"}, got.size(), exp_q.size());
    while (got.size() > 0 && exp_q.size() > 0) chk(tag, got.pop_front(), exp_q.pop_front());
    got.delete();
    exp_q.delete();
    chk({tag, " frame_err"}, err_cnt, exp_err);
`ifdef PS2_RX_KEYSTATE_EN
    chk({tag, " key_held"}, key_held, held);
`endif
  endtask
  function automatic logic [7:0] rnd_code();
    logic [7:0] arrows [4] = '{8'h75, 8'h6B, 8'h72, 8'h74};
    logic [7:0] k;
    k = 8'($urandom_range(0, 255));
    if ($urandom_range(0, 2) == 0) k = arrows[$urandom_range(0, 3)];
    return (k == 8'hE0 || k == 8'hF0) ? 8'h1C : k;
  endfunction
  initial begin
    ev.EVT_READY = 1'b1;
    clks(4);
    chk("reset valid", ev.EVT_VALID, 0);
    chk("reset code", ev.EVT_CODE, 0);
    chk("reset ext", ev.EVT_EXT, 0);
    chk("reset break", ev.EVT_BREAK, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset overflow", overflow, 0);
    rst_n = 1'b1;
    clks(4);
    send(8'h1C, 1'b0);
    chk("make 1C explicit", exp_q.size() == 1 ? 32'(exp_q[0]) : 32'hDEAD, {8'h1C, 2'b00});
    check_events("make 1C");
    send(8'hE0, 1'b0);
    send(8'h6B, 1'b0);
`ifdef PS2_RX_KEYSTATE_EN
    chk("left held", key_held[1], 1);
`endif
    check_events("ext make 6B");
    send(8'hE0, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h6B, 1'b0);
`ifdef PS2_RX_KEYSTATE_EN
    chk("left released", key_held[1], 0);
`endif
    check_events("ext break 6B");
    send(8'h75, 1'b1);
    check_events("bad parity");
    send(8'hF0, 1'b0);
    send(8'h75, 1'b0);
    check_events("break 75");
    send(8'hE0, 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)));
    ps2_data = 1'b1;
    clks((TIMEOUT_TICKS - 8) * CLK_DIV);
    chk("no early timeout", err_cnt, exp_err);
    clks(16 * CLK_DIV);
    exp_err++;
    pend_ext = 1'b0;
    pend_brk = 1'b0;
    chk("timeout frame_err", err_cnt, exp_err);
    send(8'h29, 1'b0);
    check_events("after timeout 29");
    ev.EVT_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      c[i] = rnd_code();
      send(c[i], 1'b0);
      chk("held valid", ev.EVT_VALID, 1);
      chk("held head stable", ev.EVT_CODE, c[0]);
      chk("overflow flag", overflow, i == 4);
    end
    void'(exp_q.pop_back());
    ev.EVT_READY = 1'b1;
    clks(8);
    check_events("fifo drain");
    chk("drained valid", ev.EVT_VALID, 0);
    chk("drained code zero", ev.EVT_CODE, 0);
    chk("overflow sticky", overflow, 1);
    ev.EVT_READY = 1'b0;
    send(rnd_code(), 1'b0);
    chk("pre-reset valid", ev.EVT_VALID, 1);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    rst_n = 1'b0;
    clks(2);
    rst_n = 1'b1;
    clks(1);
    chk("mid reset valid", ev.EVT_VALID, 0);
    chk("mid reset overflow", overflow, 0);
    got.delete();
    exp_q.delete();
    pend_ext = 1'b0;
    pend_brk = 1'b0;
    held = 4'd0;
    ev.EVT_READY = 1'b1;
    send(8'h5A, 1'b0);
    check_events("after reset 5A");
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2) send(8'hE0, 1'b0);
      else if (r == 2) send(8'hF0, 1'b0);
      else send(rnd_code(), r == 3);
      if (i % 10 == 9) check_events("random stream");
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/ps2_key_event_rx.md
Name: ps2_key_event_rx

Overview:
Parametrised PS/2 keyboard receiver that turns raw PS2_CLK/PS2_DATA into decoded key events (scan code plus extended and break flags). It synchronises the inputs, checks each frame, and merges the E0/F0 prefix bytes into one event. Events are buffered in a small FIFO with a valid/ready handshake. It sits between the PS/2 pins and game-control logic (arrow-key movement).

Parameters:
CLK_DIV, 250, system clocks per sample tick (>=2)
TIMEOUT_TICKS, 4000, sample ticks without a PS2_CLK fall before a partial frame is discarded
FIFO_DEPTH, 4, event FIFO entries (power of two, >=2)
SYNC_STAGES, 2, flip-flop stages on PS2_CLK and PS2_DATA (>=2)

Ports:
CLK  in  1  system clock; all logic on posedge
RESETN  in  1  synchronous reset, active-low
PS2_CLK  in  1  keyboard clock, asynchronous
PS2_DATA  in  1  keyboard data, asynchronous
EVT_VALID  out  1  FIFO head holds an event
EVT_READY  in  1  consumer accepts the head event
EVT_CODE  out  8  scan code of the head event
EVT_EXT  out  1  head event was E0-prefixed
EVT_BREAK  out  1  head event is a release (F0-prefixed)
FRAME_ERR  out  1  one-cycle pulse on a bad frame or timeout
OVERFLOW  out  1  sticky; an event was dropped because the FIFO was full
KEY_HELD  out  4  only with the macro: {right, down, left, up} held state

Behaviour:
- Reset (RESETN=0 at posedge): all outputs 0, FIFO empty, frame counter 0, prefix FSM in IDLE, tick divider 0. Synchronisers preset to 1 (bus idle).
- Tick: divider counts 0..CLK_DIV-1. TICK is high for one CLK when the count wraps. Edge detection, sampling and the timeout all advance only on TICK.
- Fall: synced PS2_CLK was 1 at the previous TICK and is 0 now. On a fall, synced PS2_DATA shifts into an 11-bit register LSB-first and BITCNT increments.
- When BITCNT reaches 11, the frame is checked on the next TICK:
  - start bit = 0
  - stop bit = 1
  - odd parity over data[7:0] plus the parity bit
  - BITCNT is cleared either way.
- Timeout: an idle counter runs while 0<BITCNT<11 and resets on every fall. At TIMEOUT_TICKS it clears BITCNT, pulses FRAME_ERR and forces the FSM to IDLE.
- Bad frame: pulse FRAME_ERR, drop the byte, FSM to IDLE.
- Prefix FSM (good bytes only):
  - IDLE: E0 -> EXT; F0 -> BRK; other -> push {code, ext=0, brk=0}.
  - EXT: F0 -> EXT_BRK; E0 -> stay; other -> push {code, 1, 0}, go IDLE.
  - BRK: other -> push {code, 0, 1}, go IDLE; E0/F0 -> IDLE, no push.
  - EXT_BRK: other -> push {code, 1, 1}, go IDLE; E0/F0 -> IDLE, no push.
- Push latency: the event is visible on EVT_* 1 CLK after the check TICK if the FIFO was empty.
- FIFO handshake:
  - Pop when EVT_VALID && EVT_READY.
  - EVT_* are stable while EVT_VALID=1 && !EVT_READY.
  - Push and pop in the same cycle are both honoured, including when full.
  - Push while full with no pop: the new event is dropped and OVERFLOW is set (cleared only by reset).
- EVT_* outputs are 0 whenever EVT_VALID=0.
- A reset during a frame discards it; the next fall starts a new frame at BITCNT=0.

Optional Feature:
Macro PS2_RX_KEYSTATE_EN.
- Defined: KEY_HELD tracks extended arrows (up 75, left 6B, down 72, right 74, with ext=1). A make sets the bit, a break clears it. Bits update on the FIFO push, independent of EVT_READY and of overflow. Reset clears them.
- Undefined: KEY_HELD port and its logic are absent.

Decomposition:
- Package ps2_pkg holds:
  - constants PS2_EXT_PREFIX=8'hE0, PS2_BRK_PREFIX=8'hF0, and the four arrow codes
  - the prefix FSM state enum
  - the event struct {code[7:0], ext, brk}
- One sub-module, ps2_frame_rx: synchroniser, tick divider, shift register, frame check and timeout. It outputs byte_valid, byte and frame_err. The top level holds the prefix FSM, the FIFO and the key state.

Test Plan:
- Send a frame for 0x1C with correct parity, EVT_READY=1 -> one event {1C, ext=0, brk=0}; FRAME_ERR stays 0.
- Send E0, F0, 6B -> exactly one event {6B, 1, 1}; with the macro, KEY_HELD[1] goes 1 after E0 6B and 0 after this sequence.
- Send 0x75 with a flipped parity bit -> FRAME_ERR pulses once, no event; a following good F0 then 75 gives {75, 0, 1}.
- Send 6 clock falls then stop for TIMEOUT_TICKS+1 ticks -> FRAME_ERR pulses; the next full frame 0x29 decodes correctly.
- Hold EVT_READY=0 and send FIFO_DEPTH+1 make codes -> EVT_VALID=1, the first code is held stable, OVERFLOW=1, and exactly FIFO_DEPTH events drain in order.
- Assert RESETN=0 mid-frame (BITCNT=5) -> FIFO empty, OVERFLOW=0, and the next frame decodes correctly.
